mips_register_file: RTL and testbench

- General-purpose register file for the pipelined MIPS datapath.
- Provides 32 x 32-bit registers with two combinational read ports (rs/rt, used by ID stage) and one synchronous write port (used by WB stage).
- Register 0 is hardwired to zero.
- Same-cycle write-to-read bypass lets WB results reach ID without an extra hazard stall.

---
 rtl/mips_register_file_if.sv | 34 +++
 rtl/mips_register_file.sv | 55 +++++
 tb/tb_mips_register_file.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mips_register_file_if.sv
// Register file access bundle.
// Read/write port signals between ID/WB and the register file.
interface mips_register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  register_write;
  logic [ADDR_WIDTH-1:0] read_register_1;
  logic [ADDR_WIDTH-1:0] read_register_2;
  logic [ADDR_WIDTH-1:0] write_register;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] read_data_1;
  logic [DATA_WIDTH-1:0] read_data_2;

  modport master (
    output register_write,
    output read_register_1,
    output read_register_2,
    output write_register,
    output write_data,
    input  read_data_1,
    input  read_data_2
  );

  modport slave (
    input  register_write,
    input  read_register_1,
    input  read_register_2,
    input  write_register,
    input  write_data,
    output read_data_1,
    output read_data_2
  );
endinterface

// File: rtl/mips_register_file.sv
// MIPS 32x32 register file, r0 hardwired to zero.
// Two combinational read ports with same-cycle WB bypass.
module mips_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input logic             clk,
  input logic             reset,
  mips_register_file_if.slave rf
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  bypass_1;
  logic                  bypass_2;
  logic                  write_en;

  assign write_en = !reset && rf.register_write;

  // Storage update: reset clears all, r0 never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (rf.register_write &&
                 rf.write_register != '0) begin
      regs[rf.write_register] <= rf.write_data;
    end
  end

  // Port 1 read: r0 zero, else bypass, else storage.
  always_comb begin
    bypass_1 = write_en &&
      (rf.write_register == rf.read_register_1);
    rf.read_data_1 = regs[rf.read_register_1];
    if (rf.read_register_1 == '0) begin
      rf.read_data_1 = '0;
    end else if (bypass_1) begin
      rf.read_data_1 = rf.write_data;
    end
  end

  // Port 2 read: r0 zero, else bypass, else storage.
  always_comb begin
    bypass_2 = write_en &&
      (rf.write_register == rf.read_register_2);
    rf.read_data_2 = regs[rf.read_register_2];
    if (rf.read_register_2 == '0) begin
      rf.read_data_2 = '0;
    end else if (bypass_2) begin
      rf.read_data_2 = rf.write_data;
    end
  end
endmodule

// File: tb/tb_mips_register_file.sv
// Directed bench for mips_register_file.
// Scenario tasks with inline checks, one summary line.
module tb_mips_register_file;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mips_register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) rf_bus ();

  mips_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .rf    (rf_bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic idle();
    rf_bus.register_write  = 1'b0;
    rf_bus.write_register  = 5'd0;
    rf_bus.write_data      = 32'h0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    rf_bus.register_write = 1'b1;
    rf_bus.write_register = a;
    rf_bus.write_data     = d;
    tick();
    idle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    rf_bus.read_register_1 = 5'd1;
    rf_bus.read_register_2 = 5'd31;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("reset_r1", rf_bus.read_data_1, 32'h0);
    chk("reset_r31", rf_bus.read_data_2, 32'h0);
  endtask

  task automatic test_basic_write();
    rf_bus.register_write  = 1'b1;
    rf_bus.write_register  = 5'd1;
    rf_bus.write_data      = 32'hFFDDABCC;
    rf_bus.read_register_1 = 5'd1;
    #1;
    chk("basic_bypass", rf_bus.read_data_1, 32'hFFDDABCC);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("basic_hold", rf_bus.read_data_1, 32'hFFDDABCC);
      tick();
    end
  endtask

  task automatic test_r0();
    rf_bus.register_write  = 1'b1;
    rf_bus.write_register  = 5'd0;
    rf_bus.write_data      = 32'h12345678;
    rf_bus.read_register_1 = 5'd0;
    rf_bus.read_register_2 = 5'd0;
    #1;
    chk("r0_nobypass_1", rf_bus.read_data_1, 32'h0);
    chk("r0_nobypass_2", rf_bus.read_data_2, 32'h0);
    tick();
    idle();
    #1;
    chk("r0_after_1", rf_bus.read_data_1, 32'h0);
    chk("r0_after_2", rf_bus.read_data_2, 32'h0);
  endtask

  task automatic test_write_disable();
    rf_bus.register_write  = 1'b0;
    rf_bus.write_register  = 5'd5;
    rf_bus.write_data      = 32'hDEADBEEF;
    rf_bus.read_register_1 = 5'd5;
    #1;
    chk("wdis_pre", rf_bus.read_data_1, 32'h0);
    for (int i = 0; i < 3; i++) tick();
    chk("wdis_post", rf_bus.read_data_1, 32'h0);
    idle();
  endtask

  task automatic test_bypass_dual();
    rf_bus.read_register_1 = 5'd7;
    rf_bus.read_register_2 = 5'd7;
    rf_bus.register_write  = 1'b1;
    rf_bus.write_register  = 5'd7;
    rf_bus.write_data      = 32'hA5A5A5A5;
    #1;
    chk("dual_byp_1", rf_bus.read_data_1, 32'hA5A5A5A5);
    chk("dual_byp_2", rf_bus.read_data_2, 32'hA5A5A5A5);
    tick();
    idle();
    #1;
    chk("dual_hold_1", rf_bus.read_data_1, 32'hA5A5A5A5);
    chk("dual_hold_2", rf_bus.read_data_2, 32'hA5A5A5A5);
  endtask

  task automatic test_independent();
    wr(5'd10, 32'h0000AAAA);
    wr(5'd20, 32'h5555_0000);
    rf_bus.read_register_1 = 5'd10;
    rf_bus.read_register_2 = 5'd20;
    #1;
    chk("ind_p1", rf_bus.read_data_1, 32'h0000AAAA);
    chk("ind_p2", rf_bus.read_data_2, 32'h55550000);
    rf_bus.read_register_1 = 5'd20;
    rf_bus.read_register_2 = 5'd10;
    #1;
    chk("ind_swap1", rf_bus.read_data_1, 32'h55550000);
    chk("ind_swap2", rf_bus.read_data_2, 32'h0000AAAA);
    rf_bus.register_write = 1'b1;
    rf_bus.write_register = 5'd10;
    rf_bus.write_data     = 32'h13579BDF;
    #1;
    chk("ind_byp_hit", rf_bus.read_data_2, 32'h13579BDF);
    chk("ind_byp_miss", rf_bus.read_data_1, 32'h55550000);
    tick();
    idle();
    chk("ind_stored", rf_bus.read_data_2, 32'h13579BDF);
  endtask

  task automatic test_reset_priority();
    wr(5'd3, 32'h11111111);
    reset = 1'b1;
    rf_bus.register_write  = 1'b1;
    rf_bus.write_register  = 5'd3;
    rf_bus.write_data      = 32'hCAFEF00D;
    rf_bus.read_register_1 = 5'd3;
    rf_bus.read_register_2 = 5'd1;
    #1;
    chk("rst_nobypass", rf_bus.read_data_1, 32'h11111111);
    tick();
    reset = 1'b0;
    idle();
    #1;
    chk("rst_prio_r3", rf_bus.read_data_1, 32'h0);
    chk("rst_clr_r1", rf_bus.read_data_2, 32'h0);
    wr(5'd31, 32'hFFFFFFFF);
    wr(5'd2, 32'h00000001);
    rf_bus.read_register_1 = 5'd31;
    rf_bus.read_register_2 = 5'd2;
    #1;
    chk("rst_r31", rf_bus.read_data_1, 32'hFFFFFFFF);
    chk("rst_r2", rf_bus.read_data_2, 32'h00000001);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle();
    rf_bus.read_register_1 = 5'd0;
    rf_bus.read_register_2 = 5'd0;
    test_reset();
    test_basic_write();
    test_r0();
    test_write_disable();
    test_bypass_dual();
    test_independent();
    test_reset_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
